alu_op_driver: RTL and testbench
================================

Name: alu_op_driver

Overview:
Initiator side of the ALU input interface. Accepts operation requests over a valid/ready handshake and drives OPA/OPB/CMD/MODE/CIN/CE/INP_VALID with the correct operand-arrival sequencing, including split-operand delivery. It waits the command-dependent ALU latency, captures RES/COUT/OFLOW/G/L/E/ERR and returns them over a response handshake. It sits between the test/control fabric and the ALU, and is the block that generates traffic the ALU assertion checks observe.

Parameters:
WIDTH, 8, operand width; RES is WIDTH+1 bits
CMD_WIDTH, 4, command field width
RES_LAT, 1, ALU result latency in cycles for non-multiply commands (1..4)
SPLIT_GAP, 3, idle cycles between the OPA-only cycle and the both-valid cycle in split mode (0..14; must stay below the ALU's 16-cycle pairing window)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  request present
REQ_READY  out  1  driver can accept request
REQ_OPA, REQ_OPB  in  WIDTH  operands
REQ_CMD  in  CMD_WIDTH  command
REQ_MODE  in  1  1=arithmetic, 0=logical
REQ_CIN  in  1  carry in
REQ_SPLIT  in  1  deliver OPA before OPB
OPA, OPB  out  WIDTH  to ALU
CMD  out  CMD_WIDTH  to ALU
MODE, CIN, CE  out  1  to ALU
INP_VALID  out  2  to ALU
RES  in  WIDTH+1  from ALU
COUT, OFLOW, G, L, E, ERR  in  1  from ALU
RSP_VALID  out  1  response present
RSP_READY  in  1  response consumer ready
RSP_RES  out  WIDTH+1  captured RES
RSP_FLAGS  out  6  captured {COUT,OFLOW,G,L,E,ERR}

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE. All ALU-side outputs are 0, INP_VALID=2'b00, CE=0, REQ_READY=0, RSP_VALID=0, RSP_RES/RSP_FLAGS=0. Any in-flight operation or pending response is discarded. REQ_READY goes to 1 on the first clock edge after RST_N deasserts.
- States: IDLE, ISSUE_A, GAP, ISSUE, WAIT, RESP.
- IDLE: REQ_READY=1 and CE=0. On REQ_VALID&&REQ_READY the driver latches all request fields. The next state is ISSUE_A if REQ_SPLIT=1, otherwise ISSUE.
- ISSUE_A (1 cycle): INP_VALID=01, OPA=latched OPA, OPB=0, CE=1. Goes to GAP if SPLIT_GAP>0, otherwise to ISSUE.
- GAP (SPLIT_GAP cycles, down-counter): INP_VALID=00, OPA is held, OPB=0, CE=1. Goes to ISSUE when the count expires.
- ISSUE (1 cycle): INP_VALID=11, both operands, CMD, MODE and CIN driven, CE=1. Goes to WAIT and loads the latency counter.
- Latency: LAT = RES_LAT+1 when MODE=1 and CMD is 9 or 10 (multiply), otherwise LAT = RES_LAT. If the ISSUE cycle is T, the driver samples the ALU outputs on the edge ending cycle T+LAT.
- WAIT: CE=1 and INP_VALID=00. CMD/MODE/CIN are held and operands are held. On the sampling edge the driver captures RES and the flags, then goes to RESP.
- RESP: CE=0 and RSP_VALID=1, with the captured data held stable. On RSP_VALID&&RSP_READY it returns to IDLE. REQ_READY stays 0 until then (backpressure, no overlap).
- Throughput: one operation in flight. A non-split op with RES_LAT=1 and RSP_READY held at 1 completes a request-to-request cycle in 4 cycles.
- The driver does not interpret ERR. An ALU error is returned like any other response.
- CMD values are not range-checked. Out-of-range commands are driven as given.
- RSP_READY asserted outside RESP has no effect.

Optional Feature:
Macro ALU_DRV_STATS_EN.
- Defined: adds outputs STAT_OPS (16 bits) and STAT_ERRS (16 bits). STAT_OPS increments on each completed response handshake. STAT_ERRS increments when that response has ERR=1. Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Non-split add: REQ_OPA=8'h0F, REQ_OPB=8'h01, REQ_MODE=1, REQ_CMD=0, REQ_CIN=0, RES_LAT=1 -> one INP_VALID=11 cycle, capture 1 cycle later, RSP_RES=9'h010, RSP_VALID in the 3rd cycle after acceptance.
- Split delivery with SPLIT_GAP=3: REQ_SPLIT=1 -> INP_VALID sequence 01,00,00,00,11. OPB=0 until the 11 cycle, and OPA holds steady throughout.
- Multiply latency: REQ_MODE=1, REQ_CMD=9, RES_LAT=1 -> capture 2 cycles after ISSUE. Check the RES value sampled at that edge, not the edge before.
- Backpressure: hold RSP_READY=0 for 5 cycles in RESP -> RSP_VALID stays 1, data stays stable, REQ_READY=0, no ALU activity. Release -> IDLE the next cycle.
- Reset mid-operation: drop RST_N during GAP -> outputs are 0 immediately, with no clock needed. After release there is no response for the aborted op and the next request proceeds normally.
- With ALU_DRV_STATS_EN defined: run 3 ops, one returning ERR=1 -> STAT_OPS=3, STAT_ERRS=1. Then reset -> both 0.

Source files
------------

// File: rtl/alu_op_driver_if.sv
// Request/response handshake bundle between the control fabric and alu_op_driver.
interface alu_op_driver_if #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
);
  logic                 REQ_VALID;
  logic                 REQ_READY;
  logic [WIDTH-1:0]     REQ_OPA;
  logic [WIDTH-1:0]     REQ_OPB;
  logic [CMD_WIDTH-1:0] REQ_CMD;
  logic                 REQ_MODE;
  logic                 REQ_CIN;
  logic                 REQ_SPLIT;
  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [WIDTH:0]       RSP_RES;
  logic [5:0]           RSP_FLAGS;

  modport master (
    output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_SPLIT, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RES, RSP_FLAGS
  );

  modport slave (
    input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_SPLIT, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RES, RSP_FLAGS
  );
endinterface

// File: rtl/alu_op_driver.sv
// ALU initiator: sequences operands (optionally split), waits the command latency, returns the result.
// Optional statistics counters are enabled with the ALU_DRV_STATS_EN macro.
module alu_op_driver #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int RES_LAT   = 1,
  parameter int SPLIT_GAP = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  alu_op_driver_if.slave       bus,
  output logic [WIDTH-1:0]     OPA,
  output logic [WIDTH-1:0]     OPB,
  output logic [CMD_WIDTH-1:0] CMD,
  output logic                 MODE,
  output logic                 CIN,
  output logic                 CE,
  output logic [1:0]           INP_VALID,
  input  logic [WIDTH:0]       RES,
  input  logic                 COUT,
  input  logic                 OFLOW,
  input  logic                 G,
  input  logic                 L,
  input  logic                 E,
  input  logic                 ERR
`ifdef ALU_DRV_STATS_EN
  ,
  output logic [15:0]          STAT_OPS,
  output logic [15:0]          STAT_ERRS
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_A = 3'd1,
    S_GAP     = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [3:0] GAP_M1 = (SPLIT_GAP > 0) ? 4'(SPLIT_GAP - 1) : 4'd0;

  state_t               state_r, state_s;
  logic [3:0]           cnt_r, cnt_s;
  logic [WIDTH-1:0]     opa_r, opa_s, opb_r, opb_s;
  logic [CMD_WIDTH-1:0] cmd_r, cmd_s;
  logic                 mode_r, mode_s, cin_r, cin_s, split_r, split_s;
  logic                 accept_s, rsp_hs_s, capture_s, is_mul_s;
  logic [3:0]           lat_m1_s;

  logic [WIDTH-1:0]     opa_o_s, opb_o_s;
  logic [CMD_WIDTH-1:0] cmd_o_s;
  logic                 mode_o_s, cin_o_s, ce_o_s;
  logic [1:0]           iv_o_s;

  logic                 req_ready_r, rsp_valid_r;
  logic [WIDTH:0]       rsp_res_r;
  logic [5:0]           rsp_flags_r;

  assign bus.REQ_READY = req_ready_r;
  assign bus.RSP_VALID = rsp_valid_r;
  assign bus.RSP_RES   = rsp_res_r;
  assign bus.RSP_FLAGS = rsp_flags_r;

  // Next-state, request latch and shared gap/latency counter
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    opa_s     = opa_r;
    opb_s     = opb_r;
    cmd_s     = cmd_r;
    mode_s    = mode_r;
    cin_s     = cin_r;
    split_s   = split_r;
    capture_s = 1'b0;
    accept_s  = (state_r == S_IDLE) && bus.REQ_VALID && req_ready_r;
    rsp_hs_s  = (state_r == S_RESP) && rsp_valid_r && bus.RSP_READY;
    is_mul_s  = mode_r && ((cmd_r == CMD_WIDTH'(9)) || (cmd_r == CMD_WIDTH'(10)));
    lat_m1_s  = is_mul_s ? 4'(RES_LAT) : 4'(RES_LAT - 1);
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          opa_s   = bus.REQ_OPA;
          opb_s   = bus.REQ_OPB;
          cmd_s   = bus.REQ_CMD;
          mode_s  = bus.REQ_MODE;
          cin_s   = bus.REQ_CIN;
          split_s = bus.REQ_SPLIT;
          state_s = bus.REQ_SPLIT ? S_ISSUE_A : S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE_A: begin
        if (SPLIT_GAP > 0) begin
          state_s = S_GAP;
          cnt_s   = GAP_M1;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_GAP: begin
        if (cnt_r == 4'd0) begin
          state_s = S_ISSUE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_ISSUE: begin
        state_s = S_WAIT;
        cnt_s   = lat_m1_s;
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          capture_s = 1'b1;
          state_s   = S_RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_hs_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // ALU-side values for the upcoming cycle; IDLE and RESP leave the bus quiet
  always_comb begin
    opa_o_s  = {WIDTH{1'b0}};
    opb_o_s  = {WIDTH{1'b0}};
    cmd_o_s  = {CMD_WIDTH{1'b0}};
    mode_o_s = 1'b0;
    cin_o_s  = 1'b0;
    ce_o_s   = 1'b0;
    iv_o_s   = 2'b00;
    case (state_s)
      S_ISSUE_A, S_GAP: begin
        opa_o_s = opa_s;
        ce_o_s  = 1'b1;
        iv_o_s  = (state_s == S_ISSUE_A) ? 2'b01 : 2'b00;
      end
      S_ISSUE, S_WAIT: begin
        opa_o_s  = opa_s;
        opb_o_s  = opb_s;
        cmd_o_s  = cmd_s;
        mode_o_s = mode_s;
        cin_o_s  = cin_s;
        ce_o_s   = 1'b1;
        iv_o_s   = (state_s == S_ISSUE) ? 2'b11 : 2'b00;
      end
      default: begin
        ce_o_s = 1'b0;
      end
    endcase
  end

  // State, counter and latched request fields
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      cmd_r   <= {CMD_WIDTH{1'b0}};
      mode_r  <= 1'b0;
      cin_r   <= 1'b0;
      split_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      opa_r   <= opa_s;
      opb_r   <= opb_s;
      cmd_r   <= cmd_s;
      mode_r  <= mode_s;
      cin_r   <= cin_s;
      split_r <= split_s;
    end
  end

  // Registered outputs; REQ_READY rises on the first edge after reset release
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OPA         <= {WIDTH{1'b0}};
      OPB         <= {WIDTH{1'b0}};
      CMD         <= {CMD_WIDTH{1'b0}};
      MODE        <= 1'b0;
      CIN         <= 1'b0;
      CE          <= 1'b0;
      INP_VALID   <= 2'b00;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_res_r   <= {(WIDTH + 1){1'b0}};
      rsp_flags_r <= 6'd0;
    end else begin
      OPA         <= opa_o_s;
      OPB         <= opb_o_s;
      CMD         <= cmd_o_s;
      MODE        <= mode_o_s;
      CIN         <= cin_o_s;
      CE          <= ce_o_s;
      INP_VALID   <= iv_o_s;
      req_ready_r <= (state_s == S_IDLE);
      rsp_valid_r <= (state_s == S_RESP);
      if (capture_s) begin
        rsp_res_r   <= RES;
        rsp_flags_r <= {COUT, OFLOW, G, L, E, ERR};
      end
    end
  end

`ifdef ALU_DRV_STATS_EN
  // Saturating completion and error counters, stepped on the response handshake
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STAT_OPS  <= 16'd0;
      STAT_ERRS <= 16'd0;
    end else if (rsp_hs_s) begin
      if (STAT_OPS != 16'hFFFF) STAT_OPS <= STAT_OPS + 16'd1;
      if (rsp_flags_r[0] && (STAT_ERRS != 16'hFFFF)) STAT_ERRS <= STAT_ERRS + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver: behavioural ALU plus directed and random operations.
module tb_alu_op_driver;
  localparam int RES_LAT   = 1;
  localparam int SPLIT_GAP = 3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic       MODE, CIN, CE;
  logic [1:0] INP_VALID;
  logic [8:0] RES;
  logic       COUT, OFLOW, G, L, E, ERR;
`ifdef ALU_DRV_STATS_EN
  logic [15:0] stat_ops, stat_errs;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int exp_ops = 0;
  int exp_errs = 0;
  logic [8:0] last_res;

  alu_op_driver_if #(.WIDTH(8), .CMD_WIDTH(4)) bus ();

  alu_op_driver #(.WIDTH(8), .CMD_WIDTH(4), .RES_LAT(RES_LAT), .SPLIT_GAP(SPLIT_GAP)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN), .CE(CE), .INP_VALID(INP_VALID),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
`ifdef ALU_DRV_STATS_EN
    , .STAT_OPS(stat_ops), .STAT_ERRS(stat_errs)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference ALU: returns {RES[8:0], COUT, OFLOW, G, L, E, ERR}
  function automatic logic [14:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] c, input logic m, input logic ci);
    logic [8:0] a9, b9, r;
    a9 = {1'b0, a};
    b9 = {1'b0, b};
    if (m) begin
      case (c)
        4'd0:    r = a9 + b9 + {8'd0, ci};
        4'd1:    r = a9 - b9;
        4'd9:    r = 9'(a9 * b9);
        4'd10:   r = 9'((a9 + 9'd1) * (b9 + 9'd1));
        default: r = a9 + b9;
      endcase
    end else begin
      case (c)
        4'd0:    r = a9 & b9;
        4'd1:    r = a9 | b9;
        default: r = a9 ^ b9;
      endcase
    end
    return {r, r[8], m && (a[7] == b[7]) && (r[7] != a[7]), a > b, a < b, a == b, c >= 4'd13};
  endfunction

  function automatic int lat_of(input logic [3:0] c, input logic m);
    return (m && (c == 4'd9 || c == 4'd10)) ? RES_LAT + 1 : RES_LAT;
  endfunction

  // Behavioural ALU: the true result is only presented in the exact sampling cycle
  int          age = 100;
  int          cur_lat = 1;
  logic [14:0] cur = 15'd0;
  always @(posedge CLK) begin
    if (INP_VALID == 2'b11) begin
      age     <= 1;
      cur     <= alu_ref(OPA, OPB, CMD, MODE, CIN);
      cur_lat <= lat_of(CMD, MODE);
    end else if (age < 100) begin
      age <= age + 1;
    end
  end
  assign {RES, COUT, OFLOW, G, L, E, ERR} = (age == cur_lat) ? cur : ~cur;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                        input logic m, input logic ci, input logic sp, input int hold);
    logic [14:0] expv;
    logic [63:0] exp_seq, obs_seq;
    logic [8:0]  held_res;
    logic [5:0]  held_flags;
    int          n, lat, cyc, w;
    logic        ok, seen11;
    expv    = alu_ref(a, b, c, m, ci);
    lat     = lat_of(c, m);
    exp_seq = 64'd0;
    n       = 0;
    if (sp) begin
      exp_seq = {exp_seq[61:0], 2'b01};
      n++;
      for (int i = 0; i < SPLIT_GAP; i++) begin
        exp_seq = {exp_seq[61:0], 2'b00};
        n++;
      end
    end
    exp_seq = {exp_seq[61:0], 2'b11};
    n++;
    for (int i = 0; i < lat; i++) begin
      exp_seq = {exp_seq[61:0], 2'b00};
      n++;
    end

    @(negedge CLK);
    bus.REQ_OPA   = a;
    bus.REQ_OPB   = b;
    bus.REQ_CMD   = c;
    bus.REQ_MODE  = m;
    bus.REQ_CIN   = ci;
    bus.REQ_SPLIT = sp;
    bus.REQ_VALID = 1'b1;
    w = 0;
    while (!bus.REQ_READY && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("req_ready", 64'(bus.REQ_READY), 64'd1);
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;

    obs_seq = 64'd0;
    ok      = 1'b1;
    seen11  = 1'b0;
    cyc     = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge CLK);
      if (bus.RSP_VALID) begin
        cyc = k;
        break;
      end
      obs_seq = {obs_seq[61:0], INP_VALID};
      if (INP_VALID == 2'b11) seen11 = 1'b1;
      else if (!seen11 && OPB !== 8'd0) ok = 1'b0;
      if (OPA !== a || CE !== 1'b1) ok = 1'b0;
    end
    chk("rsp_latency", 64'(cyc), 64'(n + 1));
    chk("inp_valid_seq", obs_seq, exp_seq);
    chk("operand_hold", 64'(ok), 64'd1);
    chk("rsp_res", 64'(bus.RSP_RES), 64'(expv[14:6]));
    chk("rsp_flags", 64'(bus.RSP_FLAGS), 64'(expv[5:0]));
    last_res   = bus.RSP_RES;
    held_res   = expv[14:6];
    held_flags = expv[5:0];

    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("backpressure", {bus.RSP_VALID, bus.REQ_READY, CE, INP_VALID, bus.RSP_RES, bus.RSP_FLAGS},
          {1'b1, 1'b0, 1'b0, 2'b00, held_res, held_flags});
    end
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
    chk("rsp_release", {bus.RSP_VALID, bus.REQ_READY}, 64'b01);
    exp_ops++;
    if (expv[0]) exp_errs++;
  endtask

  initial begin
    logic quiet;
    bus.REQ_VALID = 1'b0;
    bus.REQ_OPA   = 8'd0;
    bus.REQ_OPB   = 8'd0;
    bus.REQ_CMD   = 4'd0;
    bus.REQ_MODE  = 1'b0;
    bus.REQ_CIN   = 1'b0;
    bus.REQ_SPLIT = 1'b0;
    bus.RSP_READY = 1'b0;
    RST_N = 1'b0;
    #2;
    chk("reset_outputs", {bus.REQ_READY, bus.RSP_VALID, CE, INP_VALID, OPA, OPB, bus.RSP_RES, bus.RSP_FLAGS}, 64'd0);
`ifdef ALU_DRV_STATS_EN
    chk("reset_stats", {stat_ops, stat_errs}, 64'd0);
`endif
    @(negedge CLK);
    @(negedge CLK);
    chk("ready_held_in_reset", 64'(bus.REQ_READY), 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("ready_after_reset", 64'(bus.REQ_READY), 64'd1);

    run_op(8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0, 0);
    chk("add_res_const", 64'(last_res), 64'h010);
    run_op(8'hA5, 8'h3C, 4'd1, 1'b1, 1'b0, 1'b1, 0);
    run_op(8'h07, 8'h06, 4'd9, 1'b1, 1'b0, 1'b0, 0);
    run_op(8'h0E, 8'h02, 4'd10, 1'b1, 1'b0, 1'b1, 1);
    run_op(8'h55, 8'hAA, 4'd9, 1'b0, 1'b1, 1'b0, 5);

    // Reset asserted while the driver sits in the split gap
    @(negedge CLK);
    bus.REQ_OPA   = 8'h99;
    bus.REQ_OPB   = 8'h11;
    bus.REQ_CMD   = 4'd0;
    bus.REQ_MODE  = 1'b1;
    bus.REQ_SPLIT = 1'b1;
    bus.REQ_VALID = 1'b1;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("gap_before_reset", {CE, INP_VALID, OPA}, {1'b1, 2'b00, 8'h99});
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_reset", {CE, INP_VALID, OPA, OPB, bus.REQ_READY, bus.RSP_VALID}, 64'd0);
`ifdef ALU_DRV_STATS_EN
    chk("stats_cleared", {stat_ops, stat_errs}, 64'd0);
`endif
    exp_ops  = 0;
    exp_errs = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (bus.RSP_VALID || CE) quiet = 1'b0;
    end
    chk("no_aborted_rsp", 64'(quiet), 64'd1);

    run_op(8'h20, 8'h30, 4'd0, 1'b1, 1'b1, 1'b0, 0);
    run_op(8'h44, 8'h44, 4'd14, 1'b0, 1'b0, 1'b1, 2);
    run_op(8'hFF, 8'h02, 4'd9, 1'b1, 1'b0, 1'b0, 0);
`ifdef ALU_DRV_STATS_EN
    chk("stat_ops_3", 64'(stat_ops), 64'd3);
    chk("stat_errs_1", 64'(stat_errs), 64'd1);
`endif

    for (int i = 0; i < 12; i++) begin
      run_op(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), int'($urandom_range(0, 3)));
    end
`ifdef ALU_DRV_STATS_EN
    chk("stat_ops_final", 64'(stat_ops), 64'(exp_ops));
    chk("stat_errs_final", 64'(stat_errs), 64'(exp_errs));
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("stats_reset", {stat_ops, stat_errs}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
